// File: rtl/tbuart_fifo_xcvr.sv
// rtl/tbuart_fifo_xcvr.sv - full-duplex UART transceiver with TX/RX FIFOs and sticky error flags
module tbuart_fifo_xcvr #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 ser_tx,
    input  logic                 ser_rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    input  logic                 err_clear,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overflow
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_mem_d [FIFO_DEPTH];
    logic [PTR_W:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 ser_tx_q, ser_tx_d;
    logic                 tx_bit_end;

    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem_d [FIFO_DEPTH];
    logic [PTR_W:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic                 rx_empty, rx_full, rx_push, rx_pop, rx_good;
    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    state_t               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_done_q, rx_done_d;
    logic                 rx_sample;
    logic                 par_flag_q, par_flag_d, frm_flag_q, frm_flag_d, ovf_flag_q, ovf_flag_d;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[PTR_W] != tx_rd_q[PTR_W]) &&
                      (tx_wr_q[PTR_W-1:0] == tx_rd_q[PTR_W-1:0]);
    assign tx_push  = tx_valid && !tx_full;
    assign tx_ready = !tx_full;
    assign tx_busy  = !tx_empty || (tx_state_q != S_IDLE);
    assign ser_tx   = ser_tx_q;

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q[PTR_W-1:0]] = tx_data;
            tx_wr_d = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_bit_end = (tx_cnt_q == CNT_LAST);
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            S_IDLE:   tx_pop = !tx_empty;
            S_START:  if (tx_bit_end) tx_state_d = S_DATA;
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
            S_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = S_IDLE;
                        tx_pop     = !tx_empty;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default:  tx_state_d = S_IDLE;
        endcase
        // Popping straight out of STOP gives gap-free back-to-back frames
        if (tx_pop) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_mem_q[tx_rd_q[PTR_W-1:0]];
            tx_par_d   = (^tx_mem_q[tx_rd_q[PTR_W-1:0]]) ^ PAR_ODD;
        end
        case (tx_state_d)
            S_START:  ser_tx_d = 1'b0;
            S_DATA:   ser_tx_d = tx_shift_d[0];
            S_PARITY: ser_tx_d = tx_par_d;
            default:  ser_tx_d = 1'b1;
        endcase
    end

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[PTR_W] != rx_rd_q[PTR_W]) &&
                      (rx_wr_q[PTR_W-1:0] == rx_rd_q[PTR_W-1:0]);
    assign rx_pop   = rx_ready && !rx_empty;
    assign rx_good  = rx_done_q && !rx_perr_q && !rx_ferr_q;
    assign rx_push  = rx_good && (!rx_full || rx_pop);
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_empty ? '0 : rx_mem_q[rx_rd_q[PTR_W-1:0]];
    assign rx_parity_err = par_flag_q;
    assign rx_frame_err  = frm_flag_q;
    assign rx_overflow   = ovf_flag_q;

    always_comb begin
        rx_mem_d   = rx_mem_q;
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q[PTR_W-1:0]] = rx_shift_q;
            rx_wr_d = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        par_flag_d = (par_flag_q && !err_clear) || (rx_done_q && rx_perr_q);
        frm_flag_d = (frm_flag_q && !err_clear) || (rx_done_q && rx_ferr_q);
        ovf_flag_d = (ovf_flag_q && !err_clear) || (rx_good && rx_full && !rx_pop);
    end

    always_comb begin
        rx_s1_d    = ser_rx;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_done_d  = 1'b0;
        rx_sample  = (rx_cnt_q == CNT_LAST);
        if (rx_sample) rx_cnt_d = '0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            S_START: begin
                // Re-check the start bit at mid-bit; later samples are one full bit apart
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_s2_q != ((^rx_shift_q) ^ PAR_ODD);
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample) begin
                    rx_ferr_d = rx_ferr_q || !rx_s2_q;
                    if (rx_bit_q == STOP_LAST) begin
                        rx_state_d = S_IDLE;
                        rx_done_d  = 1'b1;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            ser_tx_q   <= 1'b1;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            ser_tx_q   <= ser_tx_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_done_q  <= rx_done_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end
endmodule

// File: tb/tb_tbuart_fifo_xcvr.sv
// tb/tb_tbuart_fifo_xcvr.sv - directed self-checking bench for tbuart_fifo_xcvr
module tb_tbuart_fifo_xcvr;
    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic lpbk  = 1'b0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic       tx_valid0 = 1'b0, rx_ready0 = 1'b0, err_clear0 = 1'b0;
    logic [7:0] tx_data0 = 8'h00;
    logic       tx_ready0, tx_busy0, ser_tx0, ser_rx0, rx_valid0, perr0, ferr0, ovf0;
    logic [7:0] rx_data0;

    logic       tx_valid1 = 1'b0, rx_ready1 = 1'b0, err_clear1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_ready1, tx_busy1, ser_tx1, rx_valid1, perr1, ferr1, ovf1;
    logic [7:0] rx_data1;

    assign ser_rx0 = lpbk ? ser_tx0 : line0;

    always #5 clock = ~clock;

    tbuart_fifo_xcvr u0 (
        .clock(clock), .reset(reset),
        .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0), .tx_busy(tx_busy0),
        .ser_tx(ser_tx0), .ser_rx(ser_rx0),
        .rx_valid(rx_valid0), .rx_data(rx_data0), .rx_ready(rx_ready0),
        .err_clear(err_clear0), .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_overflow(ovf0)
    );

    tbuart_fifo_xcvr #(.PARITY(1)) u1 (
        .clock(clock), .reset(reset),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1), .tx_busy(tx_busy1),
        .ser_tx(ser_tx1), .ser_rx(line1),
        .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_ready(rx_ready1),
        .err_clear(err_clear1), .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overflow(ovf1)
    );

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) line0 = v;
        else line1 = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic pb, input logic sb);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, pb);
        drive_bit(sel, sb);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (ser_tx0 !== 1'b1) begin errors++; $display("FAIL rst_ser_tx: got %b want 1", ser_tx0); end
        checks++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready0); end
        checks++; if (tx_busy0 !== 1'b0) begin errors++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy0); end
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid0); end
        checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data0); end
        checks++; if ({perr0, ferr0, ovf0} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {perr0, ferr0, ovf0}); end
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_tx_frame();
        logic [9:0] exp_bits;
        exp_bits = 10'b1_0011_1101_0;
        tx_valid0 = 1'b1; tx_data0 = 8'h3D;
        @(negedge clock);
        tx_valid0 = 1'b0; tx_data0 = 8'hFF;
        checks++; if (ser_tx0 !== 1'b1) begin errors++; $display("FAIL tx_pre_start: got %b want 1", ser_tx0); end
        checks++; if (tx_busy0 !== 1'b1) begin errors++; $display("FAIL tx_busy_on_push: got %b want 1", tx_busy0); end
        @(negedge clock);
        checks++; if (ser_tx0 !== 1'b0) begin errors++; $display("FAIL tx_start_latency: got %b want 0", ser_tx0); end
        repeat (8) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ser_tx0 !== exp_bits[i]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i, ser_tx0, exp_bits[i]); end
            if (i < 9) repeat (CPB) @(negedge clock);
        end
        repeat (7) @(negedge clock);
        checks++; if (tx_busy0 !== 1'b1) begin errors++; $display("FAIL tx_busy_last_stop: got %b want 1", tx_busy0); end
        @(negedge clock);
        checks++; if (tx_busy0 !== 1'b0) begin errors++; $display("FAIL tx_busy_clear: got %b want 0", tx_busy0); end
        checks++; if (ser_tx0 !== 1'b1) begin errors++; $display("FAIL tx_idle_high: got %b want 1", ser_tx0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        int got;
        b = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        got = 0;
        lpbk = 1'b1;
        @(negedge clock);
        tx_valid0 = 1'b1; tx_data0 = b[0];
        for (int c = 0; c < 1400 && got < 4; c++) begin
            @(negedge clock);
            tx_valid0 = (c < 3);
            if (c < 3) tx_data0 = b[c+1];
            if (c == 160) begin
                checks++; if (ser_tx0 !== 1'b1) begin errors++; $display("FAIL b2b_last_stop: got %b want 1", ser_tx0); end
            end
            if (c == 161) begin
                checks++; if (ser_tx0 !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b want 0", ser_tx0); end
            end
            rx_ready0 = 1'b0;
            if (rx_valid0) begin
                checks++;
                if (rx_data0 !== b[got]) begin errors++; $display("FAIL loop_byte%0d: got %h want %h", got, rx_data0, b[got]); end
                got++;
                rx_ready0 = 1'b1;
            end
        end
        @(negedge clock);
        rx_ready0 = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL loop_count: got %0d want 4", got); end
        checks++; if ({perr0, ferr0, ovf0} !== 3'b000) begin errors++; $display("FAIL loop_flags: got %b want 000", {perr0, ferr0, ovf0}); end
        repeat (30) @(negedge clock);
        lpbk = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_parity();
        send_frame(1, 8'h3D, 1'b1, 1'b0, 1'b1);
        checks++; if (perr1 !== 1'b1) begin errors++; $display("FAIL par_err_set: got %b want 1", perr1); end
        checks++; if (rx_valid1 !== 1'b0) begin errors++; $display("FAIL par_rx_valid: got %b want 0", rx_valid1); end
        checks++; if (ferr1 !== 1'b0) begin errors++; $display("FAIL par_no_frame_err: got %b want 0", ferr1); end
        err_clear1 = 1'b1;
        @(negedge clock);
        err_clear1 = 1'b0;
        checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_err_clear: got %b want 0", perr1); end
        send_frame(1, 8'h3D, 1'b1, 1'b1, 1'b1);
        checks++; if (rx_valid1 !== 1'b1 || rx_data1 !== 8'h3D) begin errors++; $display("FAIL par_good: got %b/%h want 1/3d", rx_valid1, rx_data1); end
        checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", perr1); end
        rx_ready1 = 1'b1;
        @(negedge clock);
        rx_ready1 = 1'b0;
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL frm_err_set: got %b want 1", ferr0); end
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL frm_rx_valid: got %b want 0", rx_valid0); end
        send_frame(0, 8'h61, 1'b0, 1'b0, 1'b1);
        checks++; if (rx_valid0 !== 1'b1 || rx_data0 !== 8'h61) begin errors++; $display("FAIL frm_next_good: got %b/%h want 1/61", rx_valid0, rx_data0); end
        rx_ready0 = 1'b1; err_clear0 = 1'b1;
        @(negedge clock);
        rx_ready0 = 1'b0; err_clear0 = 1'b0;
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL frm_err_clear: got %b want 0", ferr0); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b want 0", ovf0); end
        send_frame(0, 8'h14, 1'b0, 1'b0, 1'b1);
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_valid0 !== 1'b1 || rx_data0 !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL ovf_pop%0d: got %b/%h want 1/%h", i, rx_valid0, rx_data0, 8'h10 + 8'(i));
            end
            rx_ready0 = 1'b1;
            @(negedge clock);
            rx_ready0 = 1'b0;
        end
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", rx_valid0); end
        err_clear0 = 1'b1;
        @(negedge clock);
        err_clear0 = 1'b0;
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    endtask

    task automatic test_reset_mid_frame();
        tx_valid0 = 1'b1; tx_data0 = 8'hA5;
        @(negedge clock);
        tx_data0 = 8'h5A;
        @(negedge clock);
        tx_valid0 = 1'b0;
        repeat (40) @(negedge clock);
        checks++; if (tx_busy0 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", tx_busy0); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ser_tx0 !== 1'b1) begin errors++; $display("FAIL rst_mid_ser_tx: got %b want 1", ser_tx0); end
        checks++; if (tx_busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy0); end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        checks++; if (tx_busy0 !== 1'b0 || ser_tx0 !== 1'b1) begin errors++; $display("FAIL rst_mid_fifo_empty: got %b/%b want 0/1", tx_busy0, ser_tx0); end
        line0 = 1'b0;
        repeat (4) @(negedge clock);
        line0 = 1'b1;
        repeat (40) @(negedge clock);
        checks++; if (rx_valid0 !== 1'b0 || {perr0, ferr0, ovf0} !== 3'b000) begin errors++; $display("FAIL glitch_ignored: got %b/%b want 0/000", rx_valid0, {perr0, ferr0, ovf0}); end
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        checks++; if (rx_valid0 !== 1'b1 || rx_data0 !== 8'h3C) begin errors++; $display("FAIL post_glitch_rx: got %b/%h want 1/3c", rx_valid0, rx_data0); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
